// File: rtl/fourier_seq_ctrl.sv
// Frame sequencer for the RNS Fourier datapath.
// Accepts N samples on a valid/ready input stream and loads them into the
// datapath. It then runs the compute phase under a watchdog, reads the N
// (re, im) bins back and returns them on a valid/ready output stream.
// Every output comes straight from a register.
module fourier_seq_ctrl #(
  parameter int N       = 10,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          err,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic [31:0]   m_index,
  output logic          dp_reset,
  output logic [1:0]    dp_operation,
  output logic [31:0]   dp_addr,
  output logic [DW-1:0] dp_x,
  input  logic          dp_done,
  input  logic [DW-1:0] dp_y_re,
  input  logic [DW-1:0] dp_y_im
);

  // The counter must hold N itself: that value marks the end of LOAD.
  localparam int CW  = $clog2(N + 1);
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int LW  = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [WDW-1:0] WDG_LAST = WDW'(TIMEOUT - 1);
  localparam logic [LW-1:0]  LAT_END  = LW'(RD_LAT);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_COMP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_HOLD,
    S_COMPUTE,
    S_READ
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [WDW-1:0] wdog_reg, wdog_next;
  logic [LW-1:0]  wait_reg, wait_next;
  logic           busy_reg, busy_next;
  logic           frame_done_reg, frame_done_next;
  logic           err_reg, err_next;
  logic           s_ready_reg, s_ready_next;
  logic           m_valid_reg, m_valid_next;
  logic [DW-1:0]  m_re_reg, m_re_next;
  logic [DW-1:0]  m_im_reg, m_im_next;
  logic [31:0]    m_index_reg, m_index_next;
  logic           dp_reset_reg, dp_reset_next;
  logic [1:0]     op_reg, op_next;
  logic [31:0]    addr_reg, addr_next;
  logic [DW-1:0]  x_reg, x_next;

  function automatic logic [31:0] ext_addr(input logic [CW-1:0] v);
    return 32'(v);
  endfunction

  // Sequencing: the next state and the next value of every registered output.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    wdog_next       = wdog_reg;
    wait_next       = wait_reg;
    frame_done_next = 1'b0;
    err_next        = 1'b0;
    s_ready_next    = s_ready_reg;
    m_valid_next    = m_valid_reg;
    m_re_next       = m_re_reg;
    m_im_next       = m_im_reg;
    m_index_next    = m_index_reg;
    dp_reset_next   = 1'b0;
    op_next         = op_reg;
    addr_next       = addr_reg;
    x_next          = x_reg;

    case (state_reg)
      S_IDLE: begin
        s_ready_next = 1'b0;
        op_next      = OP_IDLE;
        if (start) begin
          state_next    = S_CLR;
          dp_reset_next = 1'b1;
        end
      end

      S_CLR: begin
        cnt_next     = '0;
        s_ready_next = 1'b1;
        state_next   = S_LOAD;
      end

      S_LOAD: begin
        if (s_valid && s_ready_reg) begin
          x_next    = s_data;
          addr_next = ext_addr(cnt_reg);
          cnt_next  = cnt_reg + CW'(1);
          op_next   = OP_LOAD;
          if (cnt_reg == CNT_LAST) begin
            s_ready_next = 1'b0;
            state_next   = S_HOLD;
          end
        end
      end

      // The last write stays on the bus one more cycle so it can settle.
      S_HOLD: begin
        op_next    = OP_COMP;
        wdog_next  = '0;
        state_next = S_COMPUTE;
      end

      S_COMPUTE: begin
        if (dp_done) begin
          op_next    = OP_READ;
          addr_next  = '0;
          cnt_next   = '0;
          wait_next  = '0;
          state_next = S_READ;
        end else if (wdog_reg == WDG_LAST) begin
          err_next   = 1'b1;
          op_next    = OP_IDLE;
          state_next = S_IDLE;
        end else begin
          wdog_next = wdog_reg + WDW'(1);
        end
      end

      S_READ: begin
        if (!m_valid_reg) begin
          if (wait_reg == LAT_END) begin
            m_valid_next = 1'b1;
            m_re_next    = dp_y_re;
            m_im_next    = dp_y_im;
            m_index_next = addr_reg;
          end else begin
            wait_next = wait_reg + LW'(1);
          end
        end else if (m_ready) begin
          m_valid_next = 1'b0;
          if (cnt_reg == CNT_LAST) begin
            frame_done_next = 1'b1;
            op_next         = OP_IDLE;
            state_next      = S_IDLE;
          end else begin
            cnt_next  = cnt_reg + CW'(1);
            addr_next = ext_addr(cnt_reg + CW'(1));
            wait_next = '0;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        op_next    = OP_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      wdog_reg       <= '0;
      wait_reg       <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      s_ready_reg    <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_re_reg       <= '0;
      m_im_reg       <= '0;
      m_index_reg    <= '0;
      dp_reset_reg   <= 1'b1;
      op_reg         <= OP_IDLE;
      addr_reg       <= '0;
      x_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      wdog_reg       <= wdog_next;
      wait_reg       <= wait_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
      s_ready_reg    <= s_ready_next;
      m_valid_reg    <= m_valid_next;
      m_re_reg       <= m_re_next;
      m_im_reg       <= m_im_next;
      m_index_reg    <= m_index_next;
      dp_reset_reg   <= dp_reset_next;
      op_reg         <= op_next;
      addr_reg       <= addr_next;
      x_reg          <= x_next;
    end
  end

  assign busy         = busy_reg;
  assign frame_done   = frame_done_reg;
  assign err          = err_reg;
  assign s_ready      = s_ready_reg;
  assign m_valid      = m_valid_reg;
  assign m_re         = m_re_reg;
  assign m_im         = m_im_reg;
  assign m_index      = m_index_reg;
  assign dp_reset     = dp_reset_reg;
  assign dp_operation = op_reg;
  assign dp_addr      = addr_reg;
  assign dp_x         = x_reg;

endmodule

// File: tb/tb_fourier_seq_ctrl.sv
// Bench for fourier_seq_ctrl. A behavioural datapath memory returns a
// registered transform of whatever was written to it. Expected bins are
// computed from the samples the bench sent.
module tb_fourier_seq_ctrl;
  localparam int N        = 10;
  localparam int DW       = 32;
  localparam int RD_LAT   = 1;
  localparam int TIMEOUT  = 16;
  localparam int DONE_DLY = 10;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, frame_done, err;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_re, m_im;
  logic [31:0]   m_index;
  logic          dp_reset;
  logic [1:0]    dp_operation;
  logic [31:0]   dp_addr;
  logic [DW-1:0] dp_x;
  logic          dp_done;
  logic [DW-1:0] dp_y_re, dp_y_im;

  always #5 clk = ~clk;

  fourier_seq_ctrl #(.N(N), .DW(DW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .err(err),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_index(m_index), .dp_reset(dp_reset), .dp_operation(dp_operation),
    .dp_addr(dp_addr), .dp_x(dp_x), .dp_done(dp_done),
    .dp_y_re(dp_y_re), .dp_y_im(dp_y_im)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] smp [N];
  logic [DW-1:0] mem [N];
  int sent, rcv, wr_cnt, last_w_addr, ccnt, done_dly;
  int fd_cnt, err_cnt, mv_cnt, op10_cnt, stall_idx, stall_left, cyc;
  bit alt;
  int last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The transform the datapath is assumed to compute, taken over either
  // the sent samples or the datapath memory.
  function automatic logic [DW-1:0] ref_re(input int k, input bit from_mem);
    logic [DW-1:0] acc = '0;
    for (int n = 0; n < N; n++)
      acc = acc + (from_mem ? mem[n] : smp[n]) * DW'((n * k) % N);
    return acc;
  endfunction

  function automatic logic [DW-1:0] ref_im(input int k, input bit from_mem);
    logic [DW-1:0] acc = '0;
    for (int n = 0; n < N; n++)
      acc = acc + ((from_mem ? mem[n] : smp[n]) ^ DW'(k * 7 + n));
    return acc;
  endfunction

  // Advance one clock, model the datapath, and drive both stream ends.
  task automatic tick();
    int a;
    @(posedge clk);
    #1;
    cyc++;
    dp_y_re   = ref_re(last_addr, 1'b1);
    dp_y_im   = ref_im(last_addr, 1'b1);
    last_addr = int'(dp_addr);
    a = int'(dp_addr);
    if (dp_operation == 2'b01) begin
      if (a >= 0 && a < N) mem[a] = dp_x;
      if (a != last_w_addr) begin
        check("wr_addr", 64'(dp_addr), 64'(wr_cnt));
        if (wr_cnt < N) check("wr_data", 64'(dp_x), 64'(smp[wr_cnt]));
        wr_cnt++;
        last_w_addr = a;
      end
    end
    if (dp_operation == 2'b10) begin
      op10_cnt++;
      ccnt++;
    end else begin
      ccnt = 0;
    end
    dp_done = (done_dly != 0) && (ccnt == done_dly);
    if (err) err_cnt++;
    if (frame_done) fd_cnt++;
    if (m_valid) mv_cnt++;
    s_valid = (sent < N) && (!alt || (cyc % 2 == 0));
    s_data  = (sent < N) ? smp[sent] : '0;
    if (s_valid && s_ready) sent++;
    m_ready = 1'b1;
    if (m_valid) begin
      if (int'(m_index) == stall_idx && stall_left > 0) begin
        check("stall_index", 64'(m_index), 64'(stall_idx));
        check("stall_re", 64'(m_re), 64'(ref_re(stall_idx, 1'b0)));
        check("stall_im", 64'(m_im), 64'(ref_im(stall_idx, 1'b0)));
        check("stall_addr", 64'(dp_addr), 64'(stall_idx));
        stall_left--;
        m_ready = 1'b0;
      end
      if (m_ready) begin
        check("m_index", 64'(m_index), 64'(rcv));
        check("m_re", 64'(m_re), 64'(ref_re(rcv, 1'b0)));
        check("m_im", 64'(m_im), 64'(ref_im(rcv, 1'b0)));
        rcv++;
      end
    end
  endtask

  task automatic run_frame(input bit alt_i, input int stall_i, input int dly_i, input int abort_i);
    sent = 0; rcv = 0; wr_cnt = 0; last_w_addr = -1; ccnt = 0;
    fd_cnt = 0; err_cnt = 0; mv_cnt = 0; op10_cnt = 0;
    alt = alt_i; stall_idx = stall_i; stall_left = 5; done_dly = dly_i;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_dp_reset", 64'(dp_reset), 64'(1));
    check("clr_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 300; i++) begin
      tick();
      if (abort_i >= 0 && m_valid && int'(m_index) == abort_i) break;
      if (fd_cnt > 0 || err_cnt > 0) break;
    end
    if (abort_i >= 0) begin
      check("abort_index", 64'(m_index), 64'(abort_i));
      check("abort_valid", 64'(m_valid), 64'(1));
    end else if (dly_i == 0) begin
      check("to_err_count", 64'(err_cnt), 64'(1));
      check("to_compute_cycles", 64'(op10_cnt), 64'(TIMEOUT));
      check("to_op", 64'(dp_operation), 64'(0));
      check("to_busy", 64'(busy), 64'(0));
      check("to_m_valid_seen", 64'(mv_cnt), 64'(0));
      check("to_frame_done_seen", 64'(fd_cnt), 64'(0));
      check("to_writes", 64'(wr_cnt), 64'(N));
    end else begin
      check("fd_count", 64'(fd_cnt), 64'(1));
      check("results", 64'(rcv), 64'(N));
      check("samples_taken", 64'(sent), 64'(N));
      check("writes", 64'(wr_cnt), 64'(N));
      check("err_count", 64'(err_cnt), 64'(0));
      check("end_busy", 64'(busy), 64'(0));
      check("end_op", 64'(dp_operation), 64'(0));
      check("end_m_valid", 64'(m_valid), 64'(0));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; dp_done = 1'b0; dp_y_re = '0; dp_y_im = '0;
    last_addr = 0; cyc = 0; done_dly = 0; stall_idx = -1; stall_left = 0;
    sent = N; rcv = 0; wr_cnt = 0; last_w_addr = -1; alt = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem[i] = '0;
      smp[i] = '0;
    end

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_s_ready", 64'(s_ready), 64'(0));
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_dp_reset", 64'(dp_reset), 64'(1));
      check("rst_op", 64'(dp_operation), 64'(0));
    end
    reset = 1'b0;
    tick();
    check("rel_dp_reset", 64'(dp_reset), 64'(0));
    check("rel_busy", 64'(busy), 64'(0));

    // Samples 1..N streamed back to back.
    for (int i = 0; i < N; i++) smp[i] = DW'(i + 1);
    run_frame(1'b0, -1, DONE_DLY, -1);

    // Source toggling every other cycle.
    fill_random();
    run_frame(1'b1, -1, DONE_DLY, -1);

    // Consumer stalls for five cycles on bin 3.
    fill_random();
    run_frame(1'b0, 3, DONE_DLY, -1);

    // dp_done never arrives, so the watchdog fires.
    fill_random();
    run_frame(1'b0, -1, 0, -1);

    // Reset lands in the middle of readout.
    fill_random();
    run_frame(1'b0, -1, DONE_DLY, 5);
    reset = 1'b1;
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_dp_reset", 64'(dp_reset), 64'(1));
    check("abort_s_ready", 64'(s_ready), 64'(0));
    check("abort_m_valid", 64'(m_valid), 64'(0));
    check("abort_op", 64'(dp_operation), 64'(0));
    check("abort_addr", 64'(dp_addr), 64'(0));
    check("abort_x", 64'(dp_x), 64'(0));
    check("abort_m_re", 64'(m_re), 64'(0));
    check("abort_m_im", 64'(m_im), 64'(0));
    check("abort_m_index", 64'(m_index), 64'(0));
    check("abort_pulses", 64'({frame_done, err}), 64'(0));
    reset = 1'b0;
    tick();
    check("abort_rel_dp_reset", 64'(dp_reset), 64'(0));

    // A clean frame after the abort; bins restart at index 0.
    fill_random();
    run_frame(1'b0, -1, DONE_DLY, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
